// File: rtl/timestamp_pkg.sv
// timestamp_pkg: shared state encoding and default widths for the RTIO timestamp counter
package timestamp_pkg;
    typedef enum logic [1:0] {TS_IDLE, TS_RUN, TS_HOLD} ts_state_t;
    localparam int DEFAULT_COUNTER_WIDTH = 64;
    localparam int DEFAULT_STEP = 1;
    localparam int DEFAULT_NUM_CMP = 4;
    localparam int MAX_NUM_CMP = 16;
endpackage

// File: rtl/timestamp_compare_channel.sv
// timestamp_compare_channel: armed one-shot unsigned counter >= threshold comparator
module timestamp_compare_channel
    import timestamp_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [COUNTER_WIDTH-1:0] counter,
    input  logic                     arm,
    input  logic [COUNTER_WIDTH-1:0] value,
    input  logic                     clear,
    output logic                     armed,
    output logic                     match
);
    logic [COUNTER_WIDTH-1:0] threshold;
    logic ge;
    assign ge = counter >= threshold;
    // A fresh arm overrides a pending hit on the old threshold; clear overrides everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            threshold <= '0;
            armed <= 1'b0;
            match <= 1'b0;
        end else begin
            if (arm) threshold <= value;
            armed <= !clear && (arm || (armed && !ge));
            match <= !clear && !arm && armed && ge;
        end
    end
endmodule

// File: rtl/timestamp_counter_mc.sv
// timestamp_counter_mc: run/hold/idle RTIO timestamp counter with offset load, step and compare channels
// Define TIMESTAMP_WRAP_DETECT_EN to enable the sticky wrap_flag; otherwise it is tied low.
module timestamp_counter_mc
    import timestamp_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int STEP = DEFAULT_STEP,
    parameter int NUM_CMP = DEFAULT_NUM_CMP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear,
    input  logic                     offset_en,
    input  logic [COUNTER_WIDTH-1:0] counter_offset,
    input  logic [NUM_CMP-1:0]       cmp_arm,
    input  logic [COUNTER_WIDTH-1:0] cmp_value [NUM_CMP],
    output logic [COUNTER_WIDTH-1:0] counter,
    output logic                     running,
    output logic [NUM_CMP-1:0]       cmp_armed,
    output logic [NUM_CMP-1:0]       cmp_match,
    output logic                     wrap_flag
);
    localparam logic [COUNTER_WIDTH-1:0] STEP_W = COUNTER_WIDTH'(STEP);
    ts_state_t state, state_next;
    logic [COUNTER_WIDTH-1:0] incremented;
    logic advance;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= TS_IDLE;
        else state <= state_next;
    end
    // stop beats a simultaneous start, landing in HOLD from any non-cleared state
    always_comb begin
        state_next = state;
        if (clear) state_next = TS_IDLE;
        else if (stop && (state == TS_RUN || start)) state_next = TS_HOLD;
        else if (start) state_next = TS_RUN;
    end
    assign running = state == TS_RUN;
    assign advance = running && !clear && !offset_en;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) counter <= '0;
        else if (clear) counter <= '0;
        else if (offset_en) counter <= counter_offset;
        else if (running) counter <= incremented;
    end
`ifdef TIMESTAMP_WRAP_DETECT_EN
    logic [COUNTER_WIDTH:0] sum;
    assign sum = {1'b0, counter} + {1'b0, STEP_W};
    assign incremented = sum[COUNTER_WIDTH-1:0];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wrap_flag <= 1'b0;
        else if (clear) wrap_flag <= 1'b0;
        else if (advance && sum[COUNTER_WIDTH]) wrap_flag <= 1'b1;
    end
`else
    logic unused_advance;
    assign unused_advance = advance;
    assign incremented = counter + STEP_W;
    assign wrap_flag = 1'b0;
`endif
    for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
        timestamp_compare_channel #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_ch (
            .clk    (clk),
            .reset  (reset),
            .counter(counter),
            .arm    (cmp_arm[i]),
            .value  (cmp_value[i]),
            .clear  (clear),
            .armed  (cmp_armed[i]),
            .match  (cmp_match[i])
        );
    end
endmodule

// File: tb/tb_timestamp_counter_mc.sv
// tb_timestamp_counter_mc: directed checks of three timestamp counter configurations sharing control pulses
module tb_timestamp_counter_mc;
`ifdef TIMESTAMP_WRAP_DETECT_EN
    localparam logic WRAP_EXP = 1'b1;
`else
    localparam logic WRAP_EXP = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic off_en_a = 1'b0, off_en_b = 1'b0, off_en_c = 1'b0;
    logic [63:0] off_a = '0, off_b = '0;
    logic [7:0] off_c = '0;
    logic [3:0] arm_a = '0, arm_b = '0;
    logic [0:0] arm_c = '0;
    logic [63:0] val_a [4], val_b [4];
    logic [7:0] val_c [1];
    logic [63:0] cnt_a, cnt_b;
    logic [7:0] cnt_c;
    logic run_a, run_b, run_c, wrap_a, wrap_b, wrap_c;
    logic [3:0] armed_a, armed_b, match_a, match_b;
    logic [0:0] armed_c, match_c;
    int compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    timestamp_counter_mc #(.COUNTER_WIDTH(64), .STEP(1), .NUM_CMP(4)) u_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .offset_en(off_en_a), .counter_offset(off_a), .cmp_arm(arm_a), .cmp_value(val_a),
        .counter(cnt_a), .running(run_a), .cmp_armed(armed_a), .cmp_match(match_a), .wrap_flag(wrap_a));
    timestamp_counter_mc #(.COUNTER_WIDTH(64), .STEP(3), .NUM_CMP(4)) u_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .offset_en(off_en_b), .counter_offset(off_b), .cmp_arm(arm_b), .cmp_value(val_b),
        .counter(cnt_b), .running(run_b), .cmp_armed(armed_b), .cmp_match(match_b), .wrap_flag(wrap_b));
    timestamp_counter_mc #(.COUNTER_WIDTH(8), .STEP(1), .NUM_CMP(1)) u_c (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .offset_en(off_en_c), .counter_offset(off_c), .cmp_arm(arm_c), .cmp_value(val_c),
        .counter(cnt_c), .running(run_c), .cmp_armed(armed_c), .cmp_match(match_c), .wrap_flag(wrap_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            val_a[i] = '0;
            val_b[i] = '0;
        end
        val_c[0] = '0;
        step();
        step();
        chk("rst_counter", cnt_a, 0);
        chk("rst_running", 64'(run_a), 0);
        chk("rst_armed", 64'(armed_a), 0);
        chk("rst_match", 64'(match_a), 0);
        chk("rst_wrap", 64'(wrap_a), 0);
        reset = 1'b0;
        // start at cycle 2, STEP=1, stop so the counter holds 10
        step();
        step();
        chk("idle_counter", cnt_a, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_running", 64'(run_a), 1);
        chk("start_counter", cnt_a, 0);
        for (int j = 1; j <= 9; j++) step();
        chk("run9_counter", cnt_a, 9);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_counter", cnt_a, 10);
        chk("stop_running", 64'(run_a), 0);
        chk("step3_hold", cnt_b, 30);
        step();
        step();
        chk("hold_counter", cnt_a, 10);
        // STEP=3, offset 0x100 while running, threshold 0x105
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_counter", cnt_b, 0);
        chk("clear_running", 64'(run_b), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("b_first_step", cnt_b, 3);
        off_en_b = 1'b1;
        off_b = 64'h100;
        step();
        off_en_b = 1'b0;
        chk("b_offset", cnt_b, 64'h100);
        arm_b = 4'b0001;
        val_b[0] = 64'h105;
        step();
        arm_b = '0;
        chk("b_armed", 64'(armed_b), 64'h1);
        chk("b_cnt103", cnt_b, 64'h103);
        chk("b_nomatch0", 64'(match_b), 0);
        step();
        chk("b_cnt106", cnt_b, 64'h106);
        chk("b_nomatch1", 64'(match_b), 0);
        step();
        chk("b_match", 64'(match_b), 64'h1);
        chk("b_disarmed", 64'(armed_b), 0);
        chk("b_cnt109", cnt_b, 64'h109);
        step();
        chk("b_match_oneshot", 64'(match_b), 0);
        // four channels 20, 20, 5, 1000 from zero
        clear = 1'b1;
        step();
        clear = 1'b0;
        arm_a = 4'b1111;
        val_a[0] = 64'd20;
        val_a[1] = 64'd20;
        val_a[2] = 64'd5;
        val_a[3] = 64'd1000;
        step();
        arm_a = '0;
        chk("a_armed_all", 64'(armed_a), 64'hF);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 25; j++) begin
            step();
            chk("a_multi_match", 64'(match_a), (j == 6) ? 64'h4 : (j == 21) ? 64'h3 : 64'h0);
            chk("a_multi_count", cnt_a, 64'(j));
        end
        chk("a_ch3_armed", 64'(armed_a), 64'h8);
        // channel 1 armed at 30, re-armed with 50 on the edge its match is due
        for (int j = 26; j <= 55; j++) begin
            arm_a = (j == 26 || j == 31) ? 4'b0010 : 4'b0000;
            val_a[1] = (j == 26) ? 64'd30 : 64'd50;
            step();
            arm_a = '0;
            chk("a_rearm_match", 64'(match_a), (j == 51) ? 64'h2 : 64'h0);
            chk("a_rearm_armed", 64'(armed_a), (j >= 26 && j < 51) ? 64'hA : 64'h8);
        end
        // asynchronous reset mid-run with two channels armed
        arm_a = 4'b0001;
        val_a[0] = 64'd10000;
        step();
        arm_a = '0;
        chk("a_two_armed", 64'(armed_a), 64'h9);
        #2 reset = 1'b1;
        #1;
        chk("async_counter", cnt_a, 0);
        chk("async_running", 64'(run_a), 0);
        chk("async_armed", 64'(armed_a), 0);
        chk("async_match", 64'(match_a), 0);
        chk("async_wrap", 64'(wrap_a), 0);
        step();
        reset = 1'b0;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_running", 64'(run_a), 0);
        step();
        chk("startstop_counter", cnt_a, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("hold_restart", 64'(run_a), 1);
        step();
        chk("hold_restart_cnt", cnt_a, 1);
        // 8-bit wrap from 0xFE
        clear = 1'b1;
        step();
        clear = 1'b0;
        off_en_c = 1'b1;
        off_c = 8'hFE;
        step();
        off_en_c = 1'b0;
        chk("c_offset_idle", 64'(cnt_c), 64'hFE);
        chk("c_offset_nowrap", 64'(wrap_c), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("c_start_cnt", 64'(cnt_c), 64'hFE);
        step();
        chk("c_cnt_ff", 64'(cnt_c), 64'hFF);
        chk("c_wrap_pre", 64'(wrap_c), 0);
        step();
        chk("c_cnt_00", 64'(cnt_c), 64'h00);
        chk("c_wrap_set", 64'(wrap_c), 64'(WRAP_EXP));
        step();
        chk("c_cnt_01", 64'(cnt_c), 64'h01);
        chk("c_wrap_sticky", 64'(wrap_c), 64'(WRAP_EXP));
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("c_clear_cnt", 64'(cnt_c), 0);
        chk("c_clear_wrap", 64'(wrap_c), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
